// File: rtl/pc_return_stack_if.sv
// Bus between the control unit / PC and the return-address stack.
// The control side drives op strobes; the stack drives the next-PC value and status.
interface pc_return_stack_if #(
   parameter int unsigned AW    = 10,
   parameter int unsigned DEPTH = 8
) ();
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [AW-1:0] PC_COUNT;
   logic [AW-1:0] IMM_ADDR;
   logic          JMP;
   logic          CALL;
   logic          RET;
   logic          INT_TAKE;
   logic          CLR_ERR;
   logic [AW-1:0] PC_DIN;
   logic          PC_LD;
   logic [CW-1:0] DEPTH_CNT;
   logic          OVF;
   logic          UNF;

   modport master (
      output PC_COUNT, IMM_ADDR, JMP, CALL, RET, INT_TAKE, CLR_ERR,
      input  PC_DIN, PC_LD, DEPTH_CNT, OVF, UNF
   );

   modport slave (
      input  PC_COUNT, IMM_ADDR, JMP, CALL, RET, INT_TAKE, CLR_ERR,
      output PC_DIN, PC_LD, DEPTH_CNT, OVF, UNF
   );
endinterface

// File: rtl/pc_return_stack.sv
// Next-PC source: return-address stack for CALL/RET and interrupt entry/exit,
// plus branch-target and interrupt-vector selection. PC_DIN/PC_LD are combinational.
module pc_return_stack #(
   parameter int unsigned   AW      = 10,
   parameter int unsigned   DEPTH   = 8,
   parameter logic [AW-1:0] INT_VEC = AW'(10'h3FF)
) (
   input logic                 CLK,
   input logic                 RST,
   pc_return_stack_if.slave    bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [2:0] {
      OP_NONE,
      OP_INT,
      OP_CALL,
      OP_RET,
      OP_JMP
   } op_e;

   logic [AW-1:0] stack_mem [DEPTH];
   logic [CW-1:0] cnt_q;
   logic          ovf_q;
   logic          unf_q;

   op_e           op;
   logic          full;
   logic          empty;
   logic          push;
   logic          push_ok;
   logic          pop_ok;
   logic          ovf_set;
   logic          unf_set;
   logic [PW-1:0] wr_idx;
   logic [PW-1:0] top_idx;
   logic [AW-1:0] push_val;
   logic [AW-1:0] top_val;
   logic [AW-1:0] pc_din;

   // Strict priority decode: only the winning op has any effect.
   always_comb begin
      op = OP_NONE;
      if (bus.INT_TAKE)  op = OP_INT;
      else if (bus.CALL) op = OP_CALL;
      else if (bus.RET)  op = OP_RET;
      else if (bus.JMP)  op = OP_JMP;
   end

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == CW'(0));
   assign push    = (op == OP_INT) || (op == OP_CALL);
   assign push_ok = push && !full;
   assign pop_ok  = (op == OP_RET) && !empty;
   assign ovf_set = push && full;
   assign unf_set = (op == OP_RET) && empty;

   // The count doubles as the write pointer; the top lives one below it.
   assign wr_idx  = PW'(cnt_q);
   assign top_idx = PW'(cnt_q - CW'(1));
   assign top_val = empty ? AW'(0) : stack_mem[top_idx];

   // Interrupts resume the not-yet-executed instruction; calls return past themselves.
   assign push_val = (op == OP_INT) ? bus.PC_COUNT : bus.PC_COUNT + AW'(1);

   always_comb begin
      pc_din = AW'(0);
      unique case (op)
         OP_INT:  pc_din = INT_VEC;
         OP_CALL: pc_din = bus.IMM_ADDR;
         OP_JMP:  pc_din = bus.IMM_ADDR;
         OP_RET:  pc_din = top_val;
         default: pc_din = AW'(0);
      endcase
   end

   assign bus.PC_DIN = pc_din;
   assign bus.PC_LD  = bus.INT_TAKE | bus.CALL | bus.RET | bus.JMP;

   // Storage needs no reset; occupancy is tracked entirely by cnt_q.
   always_ff @(posedge CLK) begin
      if (!RST && push_ok) begin
         stack_mem[wr_idx] <= push_val;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q <= CW'(0);
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (push_ok) begin
            cnt_q <= cnt_q + CW'(1);
         end else if (pop_ok) begin
            cnt_q <= cnt_q - CW'(1);
         end
         // A new error event outranks a simultaneous clear.
         ovf_q <= ovf_set | (ovf_q & ~bus.CLR_ERR);
         unf_q <= unf_set | (unf_q & ~bus.CLR_ERR);
      end
   end

   assign bus.DEPTH_CNT = cnt_q;
   assign bus.OVF       = ovf_q;
   assign bus.UNF       = unf_q;
endmodule

// File: tb/tb_pc_return_stack.sv
// Directed bench for pc_return_stack: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pc_return_stack;
   localparam logic [5:0] O_NONE = 6'b000000;
   localparam logic [5:0] O_JMP  = 6'b000001;
   localparam logic [5:0] O_RET  = 6'b000010;
   localparam logic [5:0] O_CALL = 6'b000100;
   localparam logic [5:0] O_INT  = 6'b001000;
   localparam logic [5:0] O_CLR  = 6'b010000;
   localparam logic [5:0] O_RST  = 6'b100000;

   typedef struct {
      string      nm;
      logic [9:0] din;
      logic       ld;
      logic [3:0] cnt;
      logic       ovf;
      logic       unf;
   } exp_t;

   logic CLK;
   logic RST;
   int   total;
   int   bad;
   exp_t sb[$];

   pc_return_stack_if #(.AW(10), .DEPTH(8)) bus ();

   pc_return_stack #(.AW(10), .DEPTH(8), .INT_VEC(10'h3FF)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input string fld, input logic [9:0] act, input logic [9:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
      end
   endtask

   // Monitor: every cycle with a pending expectation is compared mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.nm, "pc_ld", 10'(bus.PC_LD), 10'(e.ld));
            if (bus.PC_LD) chk(e.nm, "pc_din", bus.PC_DIN, e.din);
            else           chk(e.nm, "pc_din_idle", bus.PC_DIN, 10'h000);
            chk(e.nm, "depth_cnt", 10'(bus.DEPTH_CNT), 10'(e.cnt));
            chk(e.nm, "ovf", 10'(bus.OVF), 10'(e.ovf));
            chk(e.nm, "unf", 10'(bus.UNF), 10'(e.unf));
         end
      end
   end

   // One cycle of stimulus; expected cnt/ovf/unf are the values held during this cycle.
   task automatic step(input string nm, input logic [5:0] op, input logic [9:0] pc,
                       input logic [9:0] imm, input logic [9:0] din, input logic ld,
                       input int cnt, input logic ovf, input logic unf);
      exp_t e;
      @(posedge CLK);
      #1;
      RST          = op[5];
      bus.CLR_ERR  = op[4];
      bus.INT_TAKE = op[3];
      bus.CALL     = op[2];
      bus.RET      = op[1];
      bus.JMP      = op[0];
      bus.PC_COUNT = pc;
      bus.IMM_ADDR = imm;
      e.nm  = nm;
      e.din = din;
      e.ld  = ld;
      e.cnt = 4'(cnt);
      e.ovf = ovf;
      e.unf = unf;
      sb.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      total = 0;
      bad   = 0;
      RST          = 1'b1;
      bus.PC_COUNT = '0;
      bus.IMM_ADDR = '0;
      bus.JMP      = 1'b0;
      bus.CALL     = 1'b0;
      bus.RET      = 1'b0;
      bus.INT_TAKE = 1'b0;
      bus.CLR_ERR  = 1'b0;
      repeat (2) @(posedge CLK);

      step("reset_idle",  O_NONE, 10'h000, 10'h000, 10'h000, 1'b0, 0, 1'b0, 1'b0);
      step("call_020",    O_CALL, 10'h020, 10'h100, 10'h100, 1'b1, 0, 1'b0, 1'b0);
      step("after_call",  O_NONE, 10'h100, 10'h000, 10'h000, 1'b0, 1, 1'b0, 1'b0);
      step("ret_021",     O_RET,  10'h101, 10'h000, 10'h021, 1'b1, 1, 1'b0, 1'b0);
      step("after_ret",   O_NONE, 10'h021, 10'h000, 10'h000, 1'b0, 0, 1'b0, 1'b0);
      step("int_call",    O_INT | O_CALL, 10'h045, 10'h123, 10'h3FF, 1'b1, 0, 1'b0, 1'b0);
      step("reti_045",    O_RET,  10'h3FF, 10'h000, 10'h045, 1'b1, 1, 1'b0, 1'b0);
      step("jmp_call",    O_JMP | O_CALL, 10'h050, 10'h200, 10'h200, 1'b1, 0, 1'b0, 1'b0);
      step("b2b_ret",     O_RET,  10'h200, 10'h000, 10'h051, 1'b1, 1, 1'b0, 1'b0);
      step("jmp_155",     O_JMP,  10'h051, 10'h155, 10'h155, 1'b1, 0, 1'b0, 1'b0);
      step("call_060",    O_CALL, 10'h060, 10'h300, 10'h300, 1'b1, 0, 1'b0, 1'b0);
      step("ret_jmp",     O_RET | O_JMP, 10'h300, 10'h111, 10'h061, 1'b1, 1, 1'b0, 1'b0);

      // Fill: first push from 0x3FF wraps to 0x000, then 0x011..0x017.
      for (int i = 0; i < 8; i++) begin
         step("fill_call", O_CALL, (i == 0) ? 10'h3FF : 10'(16 + i - 1),
              10'(128 + i), 10'(128 + i), 1'b1, i, 1'b0, 1'b0);
      end
      step("ovf_call",    O_CALL, 10'h030, 10'h090, 10'h090, 1'b1, 8, 1'b0, 1'b0);
      step("ovf_flag",    O_NONE, 10'h090, 10'h000, 10'h000, 1'b0, 8, 1'b1, 1'b0);
      for (int k = 0; k < 8; k++) begin
         step("lifo_ret", O_RET, 10'h000, 10'h000, (k == 7) ? 10'h000 : 10'(23 - k),
              1'b1, 8 - k, 1'b1, 1'b0);
      end
      step("drained",     O_NONE, 10'h000, 10'h000, 10'h000, 1'b0, 0, 1'b1, 1'b0);
      step("clr_ovf",     O_CLR,  10'h000, 10'h000, 10'h000, 1'b0, 0, 1'b1, 1'b0);
      step("ovf_cleared", O_NONE, 10'h000, 10'h000, 10'h000, 1'b0, 0, 1'b0, 1'b0);

      step("unf_ret",     O_RET,  10'h010, 10'h000, 10'h000, 1'b1, 0, 1'b0, 1'b0);
      step("unf_flag",    O_NONE, 10'h000, 10'h000, 10'h000, 1'b0, 0, 1'b0, 1'b1);
      step("clr_unf",     O_CLR,  10'h000, 10'h000, 10'h000, 1'b0, 0, 1'b0, 1'b1);
      step("unf_cleared", O_NONE, 10'h000, 10'h000, 10'h000, 1'b0, 0, 1'b0, 1'b0);
      step("clr_and_unf", O_CLR | O_RET, 10'h000, 10'h000, 10'h000, 1'b1, 0, 1'b0, 1'b0);
      step("set_wins",    O_NONE, 10'h000, 10'h000, 10'h000, 1'b0, 0, 1'b0, 1'b1);
      step("clr_unf2",    O_CLR,  10'h000, 10'h000, 10'h000, 1'b0, 0, 1'b0, 1'b1);

      step("pre_rst_c0",  O_CALL, 10'h100, 10'h001, 10'h001, 1'b1, 0, 1'b0, 1'b0);
      step("pre_rst_c1",  O_CALL, 10'h101, 10'h001, 10'h001, 1'b1, 1, 1'b0, 1'b0);
      step("pre_rst_c2",  O_CALL, 10'h102, 10'h001, 10'h001, 1'b1, 2, 1'b0, 1'b0);
      step("rst_mid",     O_RST,  10'h001, 10'h000, 10'h000, 1'b0, 3, 1'b0, 1'b0);
      step("post_rst_ret", O_RET, 10'h000, 10'h000, 10'h000, 1'b1, 0, 1'b0, 1'b0);
      step("post_rst_unf", O_NONE, 10'h000, 10'h000, 10'h000, 1'b0, 0, 1'b0, 1'b1);

      begin
         int waited;
         waited = 0;
         while (sb.size() > 0 && waited < 10) begin
            @(negedge CLK);
            waited++;
         end
         #1;
         if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain actual=%0d required=0", sb.size());
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pc_return_stack.md
Name: pc_return_stack

Overview:
- Next-address source for the program counter: produces the 10-bit load value and load strobe the PC consumes on its next CLK edge.
- Holds a hardware return-address stack for CALL/RET and interrupt entry/exit; also selects branch targets and the fixed interrupt vector.
- Sits between the control unit (op strobes) and the PC (DIN/PC_LD); observes PC_COUNT.

Parameters:
- AW, 10, address width; matches PC width.
- DEPTH, 8, return-stack entries; power of two, minimum 2.
- INT_VEC, 10'h3FF, interrupt vector address.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset; synchronous, active-high.
- PC_COUNT  input  AW  current PC value.
- IMM_ADDR  input  AW  branch or call target from the instruction field.
- JMP  input  1  unconditional or taken-branch strobe.
- CALL  input  1  call strobe.
- RET  input  1  return strobe; also used for RETI.
- INT_TAKE  input  1  interrupt entry strobe.
- CLR_ERR  input  1  clears sticky error flags.
- PC_DIN  output  AW  combinational next-PC value, wired to PC DIN.
- PC_LD  output  1  combinational load strobe, wired to PC load.
- DEPTH_CNT  output  $clog2(DEPTH)+1  current number of stacked entries.
- OVF  output  1  sticky flag: push attempted while full.
- UNF  output  1  sticky flag: pop attempted while empty.

Behaviour:
- Reset (RST=1 at edge): stack pointer=0, DEPTH_CNT=0, OVF=0, UNF=0. Stack contents are don't-care. Op strobes are ignored in that cycle. Combinational outputs still follow the strobes, but the PC's own reset dominates.
- Op priority when strobes coincide: INT_TAKE > CALL > RET > JMP. Exactly one op acts per cycle; lower-priority strobes are ignored and cause no side effects.
- PC_LD = INT_TAKE | CALL | RET | JMP, same cycle, no latency.
- PC_DIN selection:
  - INT_TAKE: INT_VEC.
  - CALL, JMP: IMM_ADDR.
  - RET: top-of-stack, or 0 if the stack is empty.
  - No op: 0.
- Push value:
  - CALL pushes PC_COUNT+1, mod 2^AW; 10'h3FF+1 wraps to 0.
  - INT_TAKE pushes PC_COUNT unmodified: the interrupted instruction has not yet executed.
- Push timing: the entry is written at the edge, so DEPTH_CNT increments at that edge. Top-of-stack reflects the new entry from the next cycle.
- Pop (RET): DEPTH_CNT decrements at the edge. PC_DIN shows the old top during the RET cycle, which the PC captures at that same edge.
- Full (DEPTH_CNT==DEPTH) with a push:
  - Entry is discarded; pointer and DEPTH_CNT unchanged.
  - OVF set at the edge.
  - PC still loads the target; PC_LD=1.
- Empty with RET:
  - PC_DIN=0, PC_LD=1, pointer unchanged.
  - UNF set at the edge.
- OVF/UNF remain set until RST or CLR_ERR. CLR_ERR in the same cycle as a new error event: set wins.
- Back-to-back ops on consecutive cycles are supported with no bubbles. CALL then immediate RET returns the just-pushed value.
- Implementation: stack storage is a register array indexed by the pointer; no read latency on top-of-stack.
- Reset mid-sequence: stack empties immediately. A RET in the following cycle is underflow behaviour.

Test Plan:
- Reset, then idle -> DEPTH_CNT=0, OVF=0, UNF=0, PC_LD=0, PC_DIN=0.
- PC_COUNT=0x020, CALL, IMM_ADDR=0x100 -> that cycle PC_DIN=0x100, PC_LD=1. Next cycle DEPTH_CNT=1. Later RET -> PC_DIN=0x021, then DEPTH_CNT=0.
- PC_COUNT=0x045, INT_TAKE and CALL together -> PC_DIN=0x3FF, pushed value 0x045. Subsequent RET yields 0x045.
- 8 CALLs from PC_COUNT=0x3FF..., then 9th CALL -> DEPTH_CNT stays 8, OVF=1. 8 RETs return entries in LIFO order; first pushed from PC_COUNT=0x3FF returns 0x000 (wrap).
- RET on empty stack -> PC_DIN=0, PC_LD=1, UNF=1. CLR_ERR next cycle -> UNF=0. CLR_ERR plus empty RET in the same cycle -> UNF stays 1.
- Push 3 entries, assert RST, then RET -> DEPTH_CNT=0 after reset, RET gives PC_DIN=0, UNF=1.
